mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sole owner of the byte-serial RAM/IO port. Shares it between the instruction fetch path (icache miss, one 32-bit word) and the load/store buffer (1/2/4-byte loads and stores).
- Serialises each request into per-byte address/data beats and returns assembled little-endian words.
- Applies flush, round-robin fairness and IO-buffer back-pressure.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, word width for if_data, lsb_wdata and lsb_rdata

Ports:
clk  in  1  clock
rst_in  in  1  synchronous reset, active-low
rdy_in  in  1  global ready; low freezes all state and outputs
flush  in  1  ROB misprediction flush
io_buffer_full  in  1  IO write buffer full
mem_din  in  8  byte read from memory, valid the cycle after mem_a
mem_dout  out  8  byte to write
mem_a  out  ADDR_WIDTH  byte address
mem_wr  out  1  1 = write beat
if_req  in  1  fetch request, level, held until if_done
if_addr  in  ADDR_WIDTH  fetch address
if_done  out  1  one-cycle pulse; if_data valid
if_data  out  DATA_WIDTH  fetched word, held until the next if_done
lsb_req  in  1  LSB request, level, held until lsb_done
lsb_wr  in  1  1 = store
lsb_size  in  2  00 byte, 01 half, 10 word
lsb_addr  in  ADDR_WIDTH  byte address
lsb_wdata  in  DATA_WIDTH  store data, low bytes used
lsb_done  out  1  one-cycle pulse
lsb_rdata  out  DATA_WIDTH  load data, zero-extended; sign extension is done in the LSB

Behaviour:
Reset and freeze:
- When rst_in = 0 at a clock edge, all outputs and registers clear: state IDLE, mem_a = 0, mem_wr = 0, mem_dout = 0, dones = 0, data = 0, last_grant = IF.
- rdy_in = 0: every register holds its value, including mem_a and mem_wr.

States:
- IDLE, RD, WR.
- Registers: issue counter ic (0..4), receive counter rc (0..4), byte count n, and owner (IF or LSB).

Grant (from IDLE only):
- No grant in a cycle where flush, if_done or lsb_done is high. Requesters drop req in their done cycle.
- Only one requester pending: that requester wins.
- Both pending: the requester other than last_grant wins. last_grant updates at grant.
- A store is ineligible while io_buffer_full = 1 and lsb_addr[17:16] = 2'b11. IF may be granted instead.
- n = 4 for IF; for LSB, n = 1, 2 or 4 from lsb_size.

RD:
- Grant edge loads mem_a = addr and ic = 1.
- Each subsequent cycle:
  - mem_a advances by 1 while ic < n.
  - mem_din is captured into byte lane rc, and rc increments.
- With grant seen in cycle 0, addresses are on mem_a in cycles 1..n and data arrives in cycles 2..n+1.
- When rc reaches n: state returns to IDLE and mem_a = 0.
- The done pulse and data are visible in cycle n+2.

WR:
- mem_wr = 1, mem_a = addr + k and mem_dout = byte k of wdata in cycles 1..n.
- In cycle n+1: mem_wr = 0, mem_a = 0, lsb_done = 1, state = IDLE.
- Stores are not affected by flush.

Flush (flush = 1 at an edge):
- Any RD in progress (IF or LSB load) aborts: state = IDLE, mem_a = 0, no done pulse, partial data discarded.
- WR continues to completion.
- Unused lanes of if_data/lsb_rdata are 0.

Address arithmetic:
- Address arithmetic is modulo 2^ADDR_WIDTH. mem_a wraps 0xFFFFFFFF -> 0x0 with no error.

Decomposition:
- Shared constants in util.v: size encodings (SZ_B, SZ_H, SZ_W), state encodings, IO_ADDR_HI = 2'b11, grant ids.
- Natural sub-module: mem_byte_engine, the RD/WR beat counter and lane packer. mem_arbiter keeps grant, fairness, flush and IO gating.

Test Plan:
- IF only, if_addr = 0x100 with mem[0x100..0x103] = 13 05 00 00 -> mem_a = 0x100..0x103 in cycles 1-4; if_done in cycle 6 with if_data = 0x00000513.
- LSB half load at 0x202, bytes FE FF -> lsb_done in cycle 4 with lsb_rdata = 0x0000FFFE.
- LSB word store 0xDEADBEEF at 0x300 -> mem_wr = 1 for 4 cycles with mem_dout EF, BE, AD, DE; lsb_done in cycle 5; memory updated.
- Both requesters continuously pending from reset -> grant order LSB, IF, LSB, IF; no two consecutive same-owner grants.
- flush in cycle 3 of an IF read -> no if_done, mem_a = 0 the next cycle. Then flush during a store -> all 4 write beats are still issued and lsb_done pulses.
- Store byte to 0x30000 with io_buffer_full = 1 -> no mem_wr and the pending IF is served. Drop io_buffer_full -> store granted.
- rst_in low mid-RD -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the byte-serial memory arbiter
package mem_arbiter_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD = 2'd1;
  localparam logic [1:0] ST_WR = 2'd2;
  localparam logic [1:0] IO_ADDR_HI = 2'b11;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LSB = 1'b1;
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    return sz == SZ_B ? 3'd1 : sz == SZ_H ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_arbiter_byte_engine.sv
// mem_arbiter_byte_engine: per-byte beat sequencer and little-endian lane packer
module mem_arbiter_byte_engine
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          rdy_i,
  input  logic          flush_i,
  input  logic          start_i,
  input  logic          wr_i,
  input  logic [AW-1:0] addr_i,
  input  logic [2:0]    n_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [7:0]    mem_din_i,
  output logic          busy_o,
  output logic          fin_o,
  output logic [DW-1:0] word_o,
  output logic [AW-1:0] mem_a_o,
  output logic          mem_wr_o,
  output logic [7:0]    mem_dout_o
);
  logic [1:0] state_q, state_d;
  logic [2:0] ic_q, ic_d, rc_q, rc_d, n_q, n_d;
  logic pend_q, pend_d, wr_q, wr_d;
  logic [AW-1:0] a_q, a_d;
  logic [7:0] dout_q, dout_d;
  logic [DW-1:0] wd_q, wd_d, buf_q, buf_d;
  always_comb begin
    state_d = state_q;
    ic_d = ic_q;
    rc_d = rc_q;
    n_d = n_q;
    pend_d = pend_q;
    wr_d = wr_q;
    a_d = a_q;
    dout_d = dout_q;
    wd_d = wd_q;
    buf_d = buf_q;
    fin_o = 1'b0;
    if (state_q == ST_IDLE && start_i) begin
      state_d = wr_i ? ST_WR : ST_RD;
      ic_d = 3'd1;
      rc_d = 3'd0;
      n_d = n_i;
      pend_d = 1'b0;
      wr_d = wr_i;
      a_d = addr_i;
      dout_d = wr_i ? wdata_i[7:0] : 8'd0;
      wd_d = wdata_i >> 8;
      buf_d = '0;
    end else if (state_q == ST_RD && flush_i) begin
      state_d = ST_IDLE;
      a_d = '0;
    end else if (state_q == ST_RD) begin
      // memory returns a byte one cycle after its address, so the first RD cycle has nothing to capture
      pend_d = 1'b1;
      if (ic_q < n_q) begin
        a_d = a_q + AW'(1);
        ic_d = ic_q + 3'd1;
      end
      if (pend_q) begin
        buf_d = buf_q | (DW'(mem_din_i) << {rc_q, 3'b000});
        rc_d = rc_q + 3'd1;
        if (rc_q + 3'd1 == n_q) begin
          state_d = ST_IDLE;
          a_d = '0;
          fin_o = 1'b1;
        end
      end
    end else if (state_q == ST_WR && ic_q < n_q) begin
      a_d = a_q + AW'(1);
      ic_d = ic_q + 3'd1;
      dout_d = wd_q[7:0];
      wd_d = wd_q >> 8;
    end else if (state_q == ST_WR) begin
      state_d = ST_IDLE;
      a_d = '0;
      wr_d = 1'b0;
      dout_d = 8'd0;
      fin_o = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      ic_q <= 3'd0;
      rc_q <= 3'd0;
      n_q <= 3'd0;
      pend_q <= 1'b0;
      wr_q <= 1'b0;
      a_q <= '0;
      dout_q <= 8'd0;
      wd_q <= '0;
      buf_q <= '0;
    end else if (rdy_i) begin
      state_q <= state_d;
      ic_q <= ic_d;
      rc_q <= rc_d;
      n_q <= n_d;
      pend_q <= pend_d;
      wr_q <= wr_d;
      a_q <= a_d;
      dout_q <= dout_d;
      wd_q <= wd_d;
      buf_q <= buf_d;
    end
  end
  assign busy_o = state_q != ST_IDLE;
  assign word_o = buf_d;
  assign mem_a_o = a_q;
  assign mem_wr_o = wr_q;
  assign mem_dout_o = dout_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the byte-serial memory port between instruction fetch and the load/store buffer
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  io_buffer_full,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic                  lsb_req,
  input  logic                  lsb_wr,
  input  logic [1:0]            lsb_size,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [DATA_WIDTH-1:0] lsb_wdata,
  output logic                  lsb_done,
  output logic [DATA_WIDTH-1:0] lsb_rdata
);
  logic busy, fin, lsb_ok, pick_lsb, start;
  logic [DATA_WIDTH-1:0] word;
  logic last_q, last_d, if_done_q, if_done_d, lsb_done_q, lsb_done_d;
  logic [DATA_WIDTH-1:0] if_data_q, if_data_d, lsb_rdata_q, lsb_rdata_d;
  // last_q doubles as the owner of the transfer in flight, since it updates at every grant
  always_comb begin
    lsb_ok = lsb_req && !(lsb_wr && io_buffer_full && lsb_addr[17:16] == IO_ADDR_HI);
    pick_lsb = lsb_ok && (!if_req || last_q == GNT_IF);
    start = !busy && !flush && !if_done_q && !lsb_done_q && (if_req || lsb_ok);
    last_d = start ? (pick_lsb ? GNT_LSB : GNT_IF) : last_q;
    if_done_d = fin && last_q == GNT_IF;
    lsb_done_d = fin && last_q == GNT_LSB;
    if_data_d = if_done_d ? word : if_data_q;
    lsb_rdata_d = (lsb_done_d && !mem_wr) ? word : lsb_rdata_q;
  end
  mem_arbiter_byte_engine #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_engine (
    .clk        (clk),
    .rst_in     (rst_in),
    .rdy_i      (rdy_in),
    .flush_i    (flush),
    .start_i    (start),
    .wr_i       (pick_lsb && lsb_wr),
    .addr_i     (pick_lsb ? lsb_addr : if_addr),
    .n_i        (pick_lsb ? size_bytes(lsb_size) : 3'd4),
    .wdata_i    (lsb_wdata),
    .mem_din_i  (mem_din),
    .busy_o     (busy),
    .fin_o      (fin),
    .word_o     (word),
    .mem_a_o    (mem_a),
    .mem_wr_o   (mem_wr),
    .mem_dout_o (mem_dout)
  );
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      last_q <= GNT_IF;
      if_done_q <= 1'b0;
      lsb_done_q <= 1'b0;
      if_data_q <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy_in) begin
      last_q <= last_d;
      if_done_q <= if_done_d;
      lsb_done_q <= lsb_done_d;
      if_data_q <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end
  assign if_done = if_done_q;
  assign lsb_done = lsb_done_q;
  assign if_data = if_data_q;
  assign lsb_rdata = lsb_rdata_q;
endmodule
